lsu_fsm: RTL and testbench



---
 rtl/lsu_fsm_if.sv | 25 ++
 rtl/lsu_fsm.sv | 183 ++++++++++++++++++
 tb/tb_lsu_fsm.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_fsm_if.sv
// Data-memory request/grant/response bus between the load-store unit
// (master) and the data memory (slave).
interface lsu_fsm_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                data_req_o;
  logic                data_we_o;
  logic [DATA_W/8-1:0] data_be_o;
  logic [ADDR_W-1:0]   data_addr_o;
  logic [DATA_W-1:0]   data_wdata_o;
  logic                data_gnt_i;
  logic                data_rvalid_i;
  logic [DATA_W-1:0]   data_rdata_i;

  modport master (
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface

// File: rtl/lsu_fsm.sv
// Registered load-store unit: captures one core access, runs it through the
// request -> grant -> response bus handshake, returns extended load data and
// flags illegal/misaligned accesses and bus timeouts.
module lsu_fsm #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  lsu_fsm_if.master         bus,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  input  logic              lsu_req_i,
  output logic              lsu_stall_req_o,
  output logic [DATA_W-1:0] lsu_data_o,
  output logic              lsu_misalign_o,
  output logic              lsu_bus_err_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state_q;
  logic [2:0]       size_q;
  logic [OFF_W-1:0] off_q;
  logic [CNT_W-1:0] cnt_q;

  // Access decode of the incoming core request.
  logic              req_illegal;
  logic              req_misaligned;
  logic [BE_W-1:0]   req_mask;
  logic [BE_W-1:0]   req_be;
  logic [OFF_W-1:0]  req_off;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // Load-lane extraction from the returned word.
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] load_ext;

  logic [CNT_W-1:0] cnt_next;
  logic             timeout_hit;

  // Stall the core until the one DONE cycle of the access.
  assign lsu_stall_req_o = lsu_req_i & (state_q != DONE);

  assign cnt_next    = cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_next == CNT_W'(TIMEOUT));

  // Decode size legality, alignment, byte enables and replicated write data.
  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves one unassigned (no latch).
    req_misaligned = 1'b0;
    req_mask       = '0;
    req_wdata      = lsu_data_i;
    req_off        = lsu_addr_i[OFF_W-1:0];
    req_addr       = {lsu_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    req_illegal    = (lsu_size_i == 3'd7) ||
                     ((DATA_W == 32) && ((lsu_size_i == 3'd3) || (lsu_size_i == 3'd6)));
    // Sizes 4-6 share the width code of 0-2; bit 2 only selects zero-extension.
    case (lsu_size_i[1:0])
      2'd0: begin
        req_mask  = BE_W'(8'h01);
        req_wdata = {BE_W{lsu_data_i[7:0]}};
      end
      2'd1: begin
        req_misaligned = lsu_addr_i[0];
        req_mask       = BE_W'(8'h03);
        req_wdata      = {(DATA_W/16){lsu_data_i[15:0]}};
      end
      2'd2: begin
        req_misaligned = |lsu_addr_i[1:0];
        req_mask       = BE_W'(8'h0F);
        req_wdata      = {(DATA_W/32){lsu_data_i[31:0]}};
      end
      default: begin
        req_misaligned = |lsu_addr_i[2:0];
        req_mask       = '1;
        req_wdata      = lsu_data_i;
      end
    endcase
    req_be = lsu_we_i ? BE_W'(req_mask << req_off) : '0;
  end

  // Select the addressed lane and sign- or zero-extend it.
  always_comb begin
    lane     = bus.data_rdata_i >> {off_q, 3'b000};
    load_ext = lane;
    case (size_q[1:0])
      2'd0: begin
        if (size_q[2]) load_ext = DATA_W'(lane[7:0]);
        else           load_ext = DATA_W'($signed(lane[7:0]));
      end
      2'd1: begin
        if (size_q[2]) load_ext = DATA_W'(lane[15:0]);
        else           load_ext = DATA_W'($signed(lane[15:0]));
      end
      2'd2: begin
        if (size_q[2]) load_ext = DATA_W'(lane[31:0]);
        else           load_ext = DATA_W'($signed(lane[31:0]));
      end
      default: load_ext = lane;
    endcase
  end

  // Transaction FSM with all bus and core-facing outputs registered.
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!arstn_i) begin
      state_q          <= IDLE;
      size_q           <= '0;
      off_q            <= '0;
      cnt_q            <= '0;
      bus.data_req_o   <= 1'b0;
      bus.data_we_o    <= 1'b0;
      bus.data_be_o    <= '0;
      bus.data_addr_o  <= '0;
      bus.data_wdata_o <= '0;
      lsu_data_o       <= '0;
      lsu_misalign_o   <= 1'b0;
      lsu_bus_err_o    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (lsu_req_i) begin
            if (req_illegal || req_misaligned) begin
              lsu_misalign_o <= 1'b1;
              state_q        <= DONE;
            end else begin
              bus.data_req_o   <= 1'b1;
              bus.data_we_o    <= lsu_we_i;
              bus.data_be_o    <= req_be;
              bus.data_addr_o  <= req_addr;
              bus.data_wdata_o <= req_wdata;
              size_q           <= lsu_size_i;
              off_q            <= req_off;
              state_q          <= REQ;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_next;
          if (bus.data_gnt_i && bus.data_rvalid_i) begin
            bus.data_req_o <= 1'b0;
            if (!bus.data_we_o) lsu_data_o <= load_ext;
            state_q <= DONE;
          end else if (timeout_hit) begin
            bus.data_req_o <= 1'b0;
            lsu_bus_err_o  <= 1'b1;
            state_q        <= DONE;
          end else if (bus.data_gnt_i) begin
            bus.data_req_o <= 1'b0;
            state_q        <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_next;
          if (bus.data_rvalid_i) begin
            if (!bus.data_we_o) lsu_data_o <= load_ext;
            state_q <= DONE;
          end else if (timeout_hit) begin
            lsu_bus_err_o <= 1'b1;
            state_q       <= DONE;
          end
        end
        DONE: begin
          lsu_misalign_o <= 1'b0;
          lsu_bus_err_o  <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_fsm.sv
// Self-checking bench for lsu_fsm: a 32-bit and a 64-bit instance, both with
// an 8-cycle bus timeout, driven from a vector table plus hand sequences.
module tb_lsu_fsm;

  typedef struct {
    bit          wide;
    logic [31:0] addr;
    logic        we;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    int          exp_req_cyc;
    int          exp_stall;
    logic [31:0] exp_addr;
    logic [7:0]  exp_be;
    logic [63:0] exp_wdata;
    logic [63:0] exp_data;
    logic        exp_mis;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arstn32, arstn64, req32, req64, sel_wide;
  logic        gnt, rvalid;
  logic [63:0] rdata;
  logic [31:0] lsu_addr;
  logic        lsu_we;
  logic [2:0]  lsu_size;
  logic [63:0] lsu_data;

  logic        stall32, stall64, mis32, mis64, err32, err64;
  logic [31:0] data32;
  logic [63:0] data64;

  lsu_fsm_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
  lsu_fsm_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

  assign bus32.data_gnt_i    = gnt & ~sel_wide;
  assign bus32.data_rvalid_i = rvalid & ~sel_wide;
  assign bus32.data_rdata_i  = rdata[31:0];
  assign bus64.data_gnt_i    = gnt & sel_wide;
  assign bus64.data_rvalid_i = rvalid & sel_wide;
  assign bus64.data_rdata_i  = rdata;

  lsu_fsm #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) u_lsu32 (
    .clk_i(clk), .arstn_i(arstn32), .bus(bus32.master),
    .lsu_addr_i(lsu_addr), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
    .lsu_data_i(lsu_data[31:0]), .lsu_req_i(req32),
    .lsu_stall_req_o(stall32), .lsu_data_o(data32),
    .lsu_misalign_o(mis32), .lsu_bus_err_o(err32)
  );

  lsu_fsm #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(8)) u_lsu64 (
    .clk_i(clk), .arstn_i(arstn64), .bus(bus64.master),
    .lsu_addr_i(lsu_addr), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
    .lsu_data_i(lsu_data), .lsu_req_i(req64),
    .lsu_stall_req_o(stall64), .lsu_data_o(data64),
    .lsu_misalign_o(mis64), .lsu_bus_err_o(err64)
  );

  // View of whichever instance is currently under test.
  logic        cur_stall, cur_req_o, cur_we, cur_mis, cur_err;
  logic [31:0] cur_addr;
  logic [7:0]  cur_be;
  logic [63:0] cur_wdata, cur_data;
  always_comb begin
    cur_stall = sel_wide ? stall64 : stall32;
    cur_req_o = sel_wide ? bus64.data_req_o : bus32.data_req_o;
    cur_we    = sel_wide ? bus64.data_we_o : bus32.data_we_o;
    cur_mis   = sel_wide ? mis64 : mis32;
    cur_err   = sel_wide ? err64 : err32;
    cur_addr  = sel_wide ? bus64.data_addr_o : bus32.data_addr_o;
    cur_be    = sel_wide ? bus64.data_be_o : {4'h0, bus32.data_be_o};
    cur_wdata = sel_wide ? bus64.data_wdata_o : {32'h0, bus32.data_wdata_o};
    cur_data  = sel_wide ? data64 : {32'h0, data32};
  end

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [24];
  vec_t sb [$];
  int   sb_id [$];
  vec_t mon_e;
  int   mon_id;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: the DONE cycle is the only one with request high and stall low.
  always @(negedge clk) begin
    if ((req32 && !stall32) || (req64 && !stall64)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 1, 0);
      end else begin
        mon_e  = sb.pop_front();
        mon_id = sb_id.pop_front();
        check($sformatf("v%0d_data", mon_id), cur_data, mon_e.exp_data);
        check($sformatf("v%0d_misalign", mon_id), cur_mis, mon_e.exp_mis);
        check($sformatf("v%0d_bus_err", mon_id), cur_err, mon_e.exp_err);
      end
    end
  end

  // Issue one access, play the memory side, and check bus fields and stall length.
  task automatic run(input vec_t v, input int idx);
    int stalls = 0, reqc = 0, req_seen = 0, after = 0;
    bit granted = 0, done = 0;
    sel_wide = v.wide;
    @(posedge clk); #1;
    lsu_addr = v.addr; lsu_we = v.we; lsu_size = v.size; lsu_data = v.wdata;
    rdata = v.rdata;
    if (v.wide) req64 = 1'b1; else req32 = 1'b1;
    sb.push_back(v);
    sb_id.push_back(idx);
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (cur_stall) stalls++;
      if (cur_req_o) begin
        if (reqc == 0) begin
          check($sformatf("v%0d_addr", idx), cur_addr, v.exp_addr);
          check($sformatf("v%0d_be", idx), cur_be, v.exp_be);
          check($sformatf("v%0d_wdata", idx), cur_wdata, v.exp_wdata);
          check($sformatf("v%0d_we", idx), cur_we, v.we);
        end
        reqc++;
      end
      if (!cur_stall) done = 1;
      @(posedge clk); #1;
      gnt = 1'b0; rvalid = 1'b0;
      if (done) begin
        req32 = 1'b0; req64 = 1'b0;
      end else if (cur_req_o && !granted) begin
        if (req_seen == v.gnt_dly) begin
          gnt = 1'b1; granted = 1;
          if (v.rv_dly == 0) rvalid = 1'b1;
        end
        req_seen++;
      end else if (granted) begin
        after++;
        if (after == v.rv_dly) rvalid = 1'b1;
      end
    end
    req32 = 1'b0; req64 = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    check($sformatf("v%0d_done_reached", idx), done, 1);
    check($sformatf("v%0d_stall_cycles", idx), stalls, v.exp_stall);
    check($sformatf("v%0d_req_cycles", idx), reqc, v.exp_req_cyc);
    @(negedge clk);
    check($sformatf("v%0d_flags_clear", idx), {cur_mis, cur_err}, 2'b00);
  endtask

  initial begin
    arstn32 = 0; arstn64 = 0; req32 = 0; req64 = 0; sel_wide = 0;
    gnt = 0; rvalid = 0; rdata = '0;
    lsu_addr = '0; lsu_we = 0; lsu_size = '0; lsu_data = '0;

    //          wide addr    we size wdata                  rdata                  gd rv rq st exp_addr exp_be exp_wdata              exp_data               mis err
    vecs[0]  = '{0, 32'h103, 0, 3'd0, 64'h0,                 64'h80123456,          0, 1, 1, 3, 32'h100, 8'h00, 64'h0,                 64'hFFFFFF80,          0, 0};
    vecs[1]  = '{0, 32'h103, 0, 3'd4, 64'h0,                 64'h80123456,          0, 1, 1, 3, 32'h100, 8'h00, 64'h0,                 64'h00000080,          0, 0};
    vecs[2]  = '{0, 32'h22,  1, 3'd1, 64'hBEEF,              64'h0,                 4, 1, 5, 7, 32'h20,  8'h0C, 64'hBEEFBEEF,          64'h00000080,          0, 0};
    vecs[3]  = '{0, 32'h41,  0, 3'd2, 64'h0,                 64'h0,                 0, 1, 0, 1, 32'h0,   8'h00, 64'h0,                 64'h00000080,          1, 0};
    vecs[4]  = '{0, 32'h40,  0, 3'd3, 64'h0,                 64'h0,                 0, 1, 0, 1, 32'h0,   8'h00, 64'h0,                 64'h00000080,          1, 0};
    vecs[5]  = '{0, 32'h40,  0, 3'd6, 64'h0,                 64'h0,                 0, 1, 0, 1, 32'h0,   8'h00, 64'h0,                 64'h00000080,          1, 0};
    vecs[6]  = '{0, 32'h40,  0, 3'd7, 64'h0,                 64'h0,                 0, 1, 0, 1, 32'h0,   8'h00, 64'h0,                 64'h00000080,          1, 0};
    vecs[7]  = '{0, 32'h80,  0, 3'd2, 64'h0,                 64'h0,                 99,1, 8, 9, 32'h80,  8'h00, 64'h0,                 64'h00000080,          0, 1};
    vecs[8]  = '{0, 32'h2,   0, 3'd5, 64'h0,                 64'h1234ABCD,          0, 0, 1, 2, 32'h0,   8'h00, 64'h0,                 64'h00001234,          0, 0};
    vecs[9]  = '{0, 32'h2,   0, 3'd1, 64'h0,                 64'h8234ABCD,          0, 3, 1, 5, 32'h0,   8'h00, 64'h0,                 64'hFFFF8234,          0, 0};
    vecs[10] = '{0, 32'h7,   1, 3'd0, 64'h123456A5,          64'h0,                 0, 1, 1, 3, 32'h4,   8'h08, 64'hA5A5A5A5,          64'hFFFF8234,          0, 0};
    vecs[11] = '{0, 32'h10,  1, 3'd2, 64'hCAFEF00D,          64'h0,                 0, 1, 1, 3, 32'h10,  8'h0F, 64'hCAFEF00D,          64'hFFFF8234,          0, 0};
    vecs[12] = '{0, 32'h10,  0, 3'd2, 64'h0,                 64'h87654321,          0, 1, 1, 3, 32'h10,  8'h00, 64'h0,                 64'h87654321,          0, 0};
    vecs[13] = '{0, 32'h1,   0, 3'd0, 64'h0,                 64'h00007F00,          0, 1, 1, 3, 32'h0,   8'h00, 64'h0,                 64'h0000007F,          0, 0};
    vecs[14] = '{0, 32'h23,  1, 3'd1, 64'hBEEF,              64'h0,                 0, 1, 0, 1, 32'h0,   8'h00, 64'h0,                 64'h0000007F,          1, 0};
    vecs[15] = '{0, 32'h30,  0, 3'd2, 64'h0,                 64'h0,                 0, 99,1, 9, 32'h30,  8'h00, 64'h0,                 64'h0000007F,          0, 1};
    vecs[16] = '{1, 32'h4,   0, 3'd6, 64'h0,                 64'hDEADBEEF_00000000, 0, 1, 1, 3, 32'h0,   8'h00, 64'h0,                 64'h00000000_DEADBEEF, 0, 0};
    vecs[17] = '{1, 32'h4,   0, 3'd2, 64'h0,                 64'hDEADBEEF_00000000, 0, 1, 1, 3, 32'h0,   8'h00, 64'h0,                 64'hFFFFFFFF_DEADBEEF, 0, 0};
    vecs[18] = '{1, 32'h8,   1, 3'd3, 64'h01234567_89ABCDEF, 64'h0,                 1, 2, 2, 5, 32'h8,   8'hFF, 64'h01234567_89ABCDEF, 64'hFFFFFFFF_DEADBEEF, 0, 0};
    vecs[19] = '{1, 32'h8,   0, 3'd3, 64'h0,                 64'h80000000_00000001, 0, 1, 1, 3, 32'h8,   8'h00, 64'h0,                 64'h80000000_00000001, 0, 0};
    vecs[20] = '{1, 32'h6,   1, 3'd1, 64'hBEEF,              64'h0,                 0, 1, 1, 3, 32'h0,   8'hC0, 64'hBEEFBEEF_BEEFBEEF, 64'h80000000_00000001, 0, 0};
    vecs[21] = '{1, 32'h4,   0, 3'd3, 64'h0,                 64'h0,                 0, 1, 0, 1, 32'h0,   8'h00, 64'h0,                 64'h80000000_00000001, 1, 0};
    vecs[22] = '{1, 32'h7,   0, 3'd4, 64'h0,                 64'hF1000000_00000000, 0, 1, 1, 3, 32'h0,   8'h00, 64'h0,                 64'h00000000_000000F1, 0, 0};
    vecs[23] = '{1, 32'h3,   0, 3'd0, 64'h0,                 64'h00000000_FF000000, 0, 1, 1, 3, 32'h0,   8'h00, 64'h0,                 64'hFFFFFFFF_FFFFFFFF, 0, 0};

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst32_req", bus32.data_req_o, 0);
    check("rst32_bus", {bus32.data_we_o, bus32.data_be_o, bus32.data_addr_o, bus32.data_wdata_o}, 0);
    check("rst32_core", {data32, mis32, err32, stall32}, 0);
    check("rst64_req", bus64.data_req_o, 0);
    check("rst64_bus", {bus64.data_we_o, bus64.data_be_o, bus64.data_addr_o}, 0);
    check("rst64_wdata", bus64.data_wdata_o, 0);
    check("rst64_core", {mis64, err64, stall64}, 0);
    check("rst64_data", data64, 0);
    @(posedge clk); #1;
    arstn32 = 1; arstn64 = 1;

    for (int i = 0; i < 23; i++) run(vecs[i], i);

    // Back-to-back: new access held across DONE is taken on the first IDLE cycle;
    // an rvalid in REQ without a grant is ignored.
    sel_wide = 0;
    @(posedge clk); #1;
    lsu_addr = 32'h41; lsu_we = 0; lsu_size = 3'd2; lsu_data = '0; req32 = 1;
    sb.push_back('{0, 32'h41, 0, 3'd2, 64'h0, 64'h0, 0, 0, 0, 1, 32'h0, 8'h0, 64'h0, 64'h7F, 1, 0});
    sb_id.push_back(100);
    @(posedge clk); #1;
    lsu_addr = 32'h44;
    sb.push_back('{0, 32'h44, 0, 3'd2, 64'h0, 64'h0, 0, 0, 0, 0, 32'h0, 8'h0, 64'h0, 64'h11223344, 0, 0});
    sb_id.push_back(101);
    @(posedge clk); #1;
    check("b2b_idle_no_req", bus32.data_req_o, 0);
    @(posedge clk); #1;
    check("b2b_req", bus32.data_req_o, 1);
    check("b2b_addr", bus32.data_addr_o, 32'h44);
    rvalid = 1; rdata = 64'hBAD0BAD0;
    @(posedge clk); #1;
    check("b2b_req_held", bus32.data_req_o, 1);
    gnt = 1; rvalid = 1; rdata = 64'h11223344;
    @(posedge clk); #1;
    gnt = 0; rvalid = 0;
    @(posedge clk); #1;
    req32 = 0;
    check("b2b_data_hold", data32, 32'h11223344);

    // Reset in WAIT abandons the access; the late rvalid and a stray grant are ignored.
    sel_wide = 1;
    @(posedge clk); #1;
    lsu_addr = 32'h0; lsu_we = 0; lsu_size = 3'd2; rdata = 64'h55555555_55555555; req64 = 1;
    @(posedge clk); #1;
    check("rstw_req", bus64.data_req_o, 1);
    gnt = 1;
    @(posedge clk); #1;
    gnt = 0; arstn64 = 0; req64 = 0;
    @(posedge clk); #1;
    arstn64 = 1; rvalid = 1; gnt = 1;
    @(negedge clk);
    check("rstw_bus", {bus64.data_req_o, bus64.data_we_o, bus64.data_be_o, bus64.data_addr_o}, 0);
    check("rstw_wdata", bus64.data_wdata_o, 0);
    check("rstw_data", data64, 0);
    check("rstw_flags", {mis64, err64}, 0);
    @(posedge clk); #1;
    rvalid = 0; gnt = 0;
    @(negedge clk);
    check("rstw_data_ignored", data64, 0);
    check("rstw_req_idle", bus64.data_req_o, 0);
    run(vecs[23], 23);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
